// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8x8 register file with write-back bypass, pending-write
// scoreboard for hazard stalls, and a registered valid/ready operand output.
module operand_fetch #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] SrcA,
    output logic [DATA_W-1:0] SrcB,
    output logic [2:0]        ULAControl,
    output logic [2:0]        rd_out,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              illegal_op
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pending_q, pending_d;
    logic [NREGS-1:0]  pend_clr;
    logic [NREGS-1:0]  wb_mask, rd_mask;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] srca_q, srca_d;
    logic [DATA_W-1:0] srcb_q, srcb_d;
    logic [2:0]        ctl_q, ctl_d;
    logic [2:0]        rd_q, rd_d;
    logic              ill_q, ill_d;

    logic [2:0]        f_op, f_rd, f_ra, f_rb;
    logic              f_use_imm;
    logic [5:0]        f_imm;
    logic              legal, hazard, ready, accept, legal_acc;
    logic [DATA_W-1:0] rd_a, rd_b;

    assign f_op      = instr[15:13];
    assign f_rd      = instr[12:10];
    assign f_ra      = instr[9:7];
    assign f_use_imm = instr[6];
    assign f_rb      = instr[2:0];
    assign f_imm     = instr[5:0];

    always_comb begin
        legal = 1'b0;
        case (f_op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
    end

    // Hazards are judged against the scoreboard after this cycle's write-back
    // clear, so a consumer issues in the same cycle its producer writes back.
    always_comb begin
        wb_mask  = '0;
        rd_mask  = '0;
        wb_mask[wb_addr] = wb_en;
        rd_mask[f_rd]    = 1'b1;
        pend_clr = pending_q & ~wb_mask;
        hazard   = pend_clr[f_ra] | (~f_use_imm & pend_clr[f_rb]) | pend_clr[f_rd];
    end

    assign ready     = (~valid_q | out_ready) & ~hazard;
    assign accept    = instr_valid & ready;
    assign legal_acc = accept & legal;

    always_comb begin
        rd_a = regs_q[f_ra];
        if (f_ra == 3'd0)
            rd_a = '0;
        else if (wb_en && wb_addr == f_ra)
            rd_a = wb_data;

        rd_b = regs_q[f_rb];
        if (f_rb == 3'd0)
            rd_b = '0;
        else if (wb_en && wb_addr == f_rb)
            rd_b = wb_data;
    end

    always_comb begin
        pending_d = pend_clr;
        if (legal_acc && f_rd != 3'd0)
            pending_d = pending_d | rd_mask;
        pending_d[0] = 1'b0;

        valid_d = valid_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        ctl_d   = ctl_q;
        rd_d    = rd_q;
        if (legal_acc) begin
            valid_d = 1'b1;
            srca_d  = rd_a;
            srcb_d  = f_use_imm ? {{(DATA_W-6){1'b0}}, f_imm} : rd_b;
            ctl_d   = f_op;
            rd_d    = f_rd;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        ill_d = accept & ~legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wb_en && wb_addr != 3'd0) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            srca_q    <= '0;
            srcb_q    <= '0;
            ctl_q     <= '0;
            rd_q      <= '0;
            ill_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            srca_q    <= srca_d;
            srcb_q    <= srcb_d;
            ctl_q     <= ctl_d;
            rd_q      <= rd_d;
            ill_q     <= ill_d;
        end
    end

    assign instr_ready = ready;
    assign out_valid   = valid_q;
    assign SrcA        = srca_q;
    assign SrcB        = srcb_q;
    assign ULAControl  = ctl_q;
    assign rd_out      = rd_q;
    assign illegal_op  = ill_q;

endmodule
